// File: rtl/score_pulse_gen_pkg.sv
// Shared playfield geometry and FSM state type for the score path.
// Used by score_pulse_gen, the collision detector and the pipe scroller.
package score_pkg;

    localparam int unsigned COL_W_DEF    = 4;
    localparam int unsigned BIRD_COL_DEF = 4;
    localparam int unsigned PIPE_W_DEF   = 2;
    localparam int unsigned COUNT_W_DEF  = 8;
    localparam int unsigned STRETCH_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPROACH,
        OVERLAP,
        CLEARED,
        DEAD
    } state_t;

endpackage

// File: rtl/score_pulse_gen_pulse_stretch.sv
// Holds led high for STRETCH cycles after each pulse; a new pulse reloads the hold.
module pulse_stretch
    import score_pkg::*;
#(
    parameter int unsigned STRETCH = STRETCH_DEF
) (
    input  logic Clock,
    input  logic RST,
    input  logic pulse,
    output logic led
);

    localparam int unsigned CNT_W = $clog2(STRETCH + 1);

    logic [CNT_W-1:0] cnt;

    // led goes high with the pulse and drops once the count has run out
    always_ff @(posedge Clock) begin
        if (RST) begin
            cnt <= '0;
            led <= 1'b0;
        end else if (pulse) begin
            cnt <= CNT_W'(STRETCH);
            led <= 1'b1;
        end else begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            led <= (cnt > CNT_W'(1));
        end
    end

endmodule

// File: rtl/score_pulse_gen.sv
// Scoreboard feeder: one counter2 pulse per cleanly passed pipe, game-over latch, pass count.
// Optional SCORE_LED_STRETCH_EN drives a stretched score_led; otherwise score_led is 0.
module score_pulse_gen
    import score_pkg::*;
#(
    parameter int unsigned COL_W    = COL_W_DEF,
    parameter int unsigned BIRD_COL = BIRD_COL_DEF,
    parameter int unsigned PIPE_W   = PIPE_W_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF,
    parameter int unsigned STRETCH  = STRETCH_DEF
) (
    input  logic               Clock,
    input  logic               RST,
    input  logic               game_active,
    input  logic               pipe_valid,
    input  logic [COL_W-1:0]   pipe_col,
    input  logic               collision,
    output logic               counter2,
    output logic               game_over,
    output logic [COUNT_W-1:0] pipes_passed,
    output logic               score_led
);

    localparam int unsigned CW = COL_W + 1;
    localparam logic [CW-1:0] BIRD_X   = CW'(BIRD_COL);
    localparam logic [CW-1:0] PASS_MAX = CW'(BIRD_COL - PIPE_W);

    logic [CW-1:0] col_x;
    logic          ahead_c;
    logic          overlap_c;
    logic          passed_c;
    logic          run_c;
    logic          score_c;
    state_t        state;
    state_t        state_nxt;

    assign col_x     = {1'b0, pipe_col};
    assign ahead_c   = (col_x > BIRD_X);
    assign overlap_c = (col_x > PASS_MAX) && (col_x <= BIRD_X);
    assign passed_c  = (col_x <= PASS_MAX);
    assign run_c     = game_active & pipe_valid;

    always_ff @(posedge Clock) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Collision beats a pause, which beats any region-driven move
    always_comb begin
        state_nxt = state;
        score_c   = 1'b0;
        case (state)
            IDLE: begin
                if (run_c && ahead_c) begin
                    state_nxt = APPROACH;
                end
            end
            APPROACH, OVERLAP, CLEARED: begin
                if (collision) begin
                    state_nxt = DEAD;
                end else if (!run_c) begin
                    state_nxt = IDLE;
                end else if (state == APPROACH) begin
                    if (overlap_c) begin
                        state_nxt = OVERLAP;
                    end
                end else if (state == OVERLAP) begin
                    if (passed_c) begin
                        state_nxt = CLEARED;
                        score_c   = 1'b1;
                    end else if (ahead_c) begin
                        state_nxt = APPROACH;
                    end
                end else if (ahead_c) begin
                    state_nxt = APPROACH;
                end
            end
            DEAD: begin
                state_nxt = DEAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // game_over tracks the state being entered so it is high for exactly the DEAD cycles
    always_ff @(posedge Clock) begin
        if (RST) begin
            counter2     <= 1'b0;
            game_over    <= 1'b0;
            pipes_passed <= '0;
        end else begin
            counter2  <= score_c;
            game_over <= (state_nxt == DEAD);
            if (score_c && (pipes_passed != '1)) begin
                pipes_passed <= pipes_passed + COUNT_W'(1);
            end
        end
    end

`ifdef SCORE_LED_STRETCH_EN
    pulse_stretch #(
        .STRETCH(STRETCH)
    ) u_pulse_stretch (
        .Clock(Clock),
        .RST  (RST),
        .pulse(score_c),
        .led  (score_led)
    );
`else
    logic unused_stretch_c;
    assign unused_stretch_c = |32'(STRETCH);
    assign score_led        = 1'b0;
`endif

endmodule

// File: tb/tb_score_pulse_gen.sv
// Self-checking bench for score_pulse_gen: directed scenarios plus randomized run against a pipe-tracking model.
module tb_score_pulse_gen;

    localparam int BIRD = 4;
    localparam int PW   = 2;
    localparam int STR  = 4;

    logic       Clock = 1'b0;
    logic       RST = 1'b1;
    logic       game_active = 1'b0;
    logic       pipe_valid = 1'b0;
    logic       collision = 1'b0;
    logic [3:0] pipe_col = 4'd0;

    logic       counter2, game_over, score_led;
    logic [7:0] pipes_passed;
    logic       counter2_s, game_over_s, score_led_s;
    logic [1:0] pipes_passed_s;

    score_pulse_gen dut (
        .Clock(Clock), .RST(RST), .game_active(game_active), .pipe_valid(pipe_valid),
        .pipe_col(pipe_col), .collision(collision), .counter2(counter2),
        .game_over(game_over), .pipes_passed(pipes_passed), .score_led(score_led)
    );

    score_pulse_gen #(.COUNT_W(2)) dut_sat (
        .Clock(Clock), .RST(RST), .game_active(game_active), .pipe_valid(pipe_valid),
        .pipe_col(pipe_col), .collision(collision), .counter2(counter2_s),
        .game_over(game_over_s), .pipes_passed(pipes_passed_s), .score_led(score_led_s)
    );

    always #5 Clock = ~Clock;

    int n_total = 0;
    int n_pass  = 0;

    // Model: a pipe is tracked from when it is seen ahead; it scores once if seen overlapping then passed
    bit m_dead, m_track, m_ovl, m_scored, m_pulse;
    int m_count, m_led_cnt;
    int seen_pulses, seen_sat_pulses, exp_pulses, led_cycles;

    task automatic tick();
        int c;
        bit ahead, ovl;
        c     = int'(pipe_col);
        ahead = (c > BIRD);
        ovl   = (c > BIRD - PW) && (c <= BIRD);
        if (RST) begin
            m_dead = 0; m_track = 0; m_ovl = 0; m_scored = 0; m_pulse = 0;
            m_count = 0; m_led_cnt = 0;
        end else begin
            m_pulse = 0;
            if (!m_dead && m_track) begin
                if (collision) begin
                    m_dead = 1; m_track = 0;
                end else if (!game_active || !pipe_valid) begin
                    m_track = 0;
                end else if (ahead) begin
                    m_ovl = 0; m_scored = 0;
                end else if (ovl) begin
                    if (!m_scored) m_ovl = 1;
                end else if (m_ovl && !m_scored) begin
                    m_pulse = 1; m_scored = 1;
                end
            end else if (!m_dead && game_active && pipe_valid && ahead) begin
                m_track = 1; m_ovl = 0; m_scored = 0;
            end
            if (m_pulse) m_count++;
            if (m_pulse) m_led_cnt = STR;
            else if (m_led_cnt > 0) m_led_cnt--;
        end
        @(posedge Clock);
        #1;
        if (counter2) seen_pulses++;
        if (counter2_s) seen_sat_pulses++;
        if (m_pulse) exp_pulses++;
        if (score_led) led_cycles++;
    endtask

    task automatic sweep(input int hi, input int lo);
        game_active = 1; pipe_valid = 1; collision = 0;
        for (int c = hi; c >= lo; c--) begin
            pipe_col = 4'(c);
            tick();
        end
    endtask

    task automatic do_reset();
        RST = 1; collision = 0;
        tick();
        RST = 0;
        seen_pulses = 0; seen_sat_pulses = 0; exp_pulses = 0; led_cycles = 0;
    endtask

    task automatic test_reset();
        RST = 1; game_active = 1; pipe_valid = 1; pipe_col = 4'd3; collision = 1;
        tick();
        n_total++; if (counter2 !== 1'b0) $display("FAIL reset_counter2 got=%b exp=0", counter2); else n_pass++;
        n_total++; if (game_over !== 1'b0) $display("FAIL reset_game_over got=%b exp=0", game_over); else n_pass++;
        n_total++; if (pipes_passed !== 8'd0) $display("FAIL reset_pipes_passed got=%0d exp=0", pipes_passed); else n_pass++;
        n_total++; if (score_led !== 1'b0) $display("FAIL reset_score_led got=%b exp=0", score_led); else n_pass++;
        do_reset();
    endtask

    task automatic test_clean_pass();
        do_reset();
        sweep(15, 3);
        n_total++; if (seen_pulses !== 0) $display("FAIL clean_early_pulse got=%0d exp=0", seen_pulses); else n_pass++;
        pipe_col = 4'd2;
        tick();
        n_total++; if (counter2 !== 1'b1) $display("FAIL clean_pulse_latency got=%b exp=1", counter2); else n_pass++;
        n_total++; if (pipes_passed !== 8'd1) $display("FAIL clean_count got=%0d exp=1", pipes_passed); else n_pass++;
        tick();
        n_total++; if (counter2 !== 1'b0) $display("FAIL clean_pulse_width got=%b exp=0", counter2); else n_pass++;
        sweep(1, 0);
        for (int i = 0; i < 6; i++) tick();
        n_total++; if (seen_pulses !== 1) $display("FAIL clean_single_pulse got=%0d exp=1", seen_pulses); else n_pass++;
        n_total++; if (pipes_passed !== 8'd1) $display("FAIL clean_count_hold got=%0d exp=1", pipes_passed); else n_pass++;
    endtask

    task automatic test_collision_overlap();
        do_reset();
        sweep(15, 4);
        pipe_col = 4'd3; collision = 1;
        tick();
        collision = 0;
        n_total++; if (game_over !== 1'b1) $display("FAIL coll_game_over got=%b exp=1", game_over); else n_pass++;
        sweep(2, 0);
        sweep(15, 0);
        n_total++; if (seen_pulses !== 0) $display("FAIL coll_no_pulse got=%0d exp=0", seen_pulses); else n_pass++;
        n_total++; if (game_over !== 1'b1) $display("FAIL coll_dead_held got=%b exp=1", game_over); else n_pass++;
        do_reset();
        n_total++; if (game_over !== 1'b0) $display("FAIL coll_reset_game_over got=%b exp=0", game_over); else n_pass++;
        sweep(15, 0);
        n_total++; if (seen_pulses !== 1) $display("FAIL coll_after_reset_pulse got=%0d exp=1", seen_pulses); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        sweep(15, 0);
        seen_pulses = 0;
        sweep(15, 3);
        pipe_col = 4'd2; collision = 1;
        tick();
        collision = 0;
        n_total++; if (counter2 !== 1'b0) $display("FAIL simul_counter2 got=%b exp=0", counter2); else n_pass++;
        n_total++; if (game_over !== 1'b1) $display("FAIL simul_game_over got=%b exp=1", game_over); else n_pass++;
        n_total++; if (pipes_passed !== 8'd1) $display("FAIL simul_count got=%0d exp=1", pipes_passed); else n_pass++;
        n_total++; if (seen_pulses !== 0) $display("FAIL simul_no_pulse got=%0d exp=0", seen_pulses); else n_pass++;
    endtask

    task automatic test_multi_saturate();
        do_reset();
        for (int p = 0; p < 5; p++) sweep(15, 0);
        n_total++; if (pipes_passed_s !== 2'd3) $display("FAIL sat_count5 got=%0d exp=3", pipes_passed_s); else n_pass++;
        n_total++; if (seen_sat_pulses !== 5) $display("FAIL sat_pulses5 got=%0d exp=5", seen_sat_pulses); else n_pass++;
        for (int p = 0; p < 5; p++) sweep(15, 0);
        n_total++; if (seen_pulses !== 10) $display("FAIL multi_pulses got=%0d exp=10", seen_pulses); else n_pass++;
        n_total++; if (pipes_passed !== 8'd10) $display("FAIL multi_count got=%0d exp=10", pipes_passed); else n_pass++;
        n_total++; if (pipes_passed_s !== 2'd3) $display("FAIL sat_count10 got=%0d exp=3", pipes_passed_s); else n_pass++;
    endtask

    task automatic test_pause_reset();
        do_reset();
        sweep(15, 3);
        game_active = 0;
        tick();
        n_total++; if (game_over !== 1'b0) $display("FAIL pause_game_over got=%b exp=0", game_over); else n_pass++;
        game_active = 1;
        pipe_col = 4'd2; tick(); tick(); tick();
        pipe_col = 4'd3; tick();
        pipe_col = 4'd2; tick();
        pipe_col = 4'd4; tick();
        pipe_col = 4'd2; tick();
        n_total++; if (seen_pulses !== 0) $display("FAIL pause_no_pulse got=%0d exp=0", seen_pulses); else n_pass++;
        sweep(5, 2);
        n_total++; if (seen_pulses !== 1) $display("FAIL pause_resume_pulse got=%0d exp=1", seen_pulses); else n_pass++;
        do_reset();
        sweep(15, 3);
        RST = 1;
        tick();
        n_total++; if ({counter2, game_over, score_led} !== 3'b000) $display("FAIL midreset_flags got=%b exp=000", {counter2, game_over, score_led}); else n_pass++;
        n_total++; if (pipes_passed !== 8'd0) $display("FAIL midreset_count got=%0d exp=0", pipes_passed); else n_pass++;
        RST = 0;
        pipe_col = 4'd2; tick(); tick();
        n_total++; if (seen_pulses !== 0) $display("FAIL midreset_no_pulse got=%0d exp=0", seen_pulses); else n_pass++;
    endtask

    task automatic test_score_led();
        do_reset();
`ifdef SCORE_LED_STRETCH_EN
        sweep(15, 2);
        pipe_col = 4'd0;
        for (int i = 0; i < 10; i++) tick();
        n_total++; if (led_cycles !== STR) $display("FAIL led_single got=%0d exp=%0d", led_cycles, STR); else n_pass++;
        sweep(15, 2);
        led_cycles = 0;
        pipe_col = 4'd15; tick();
        pipe_col = 4'd3;  tick();
        pipe_col = 4'd2;  tick();
        pipe_col = 4'd0;
        for (int i = 0; i < 10; i++) tick();
        // first pulse already counted as one led cycle before led_cycles was cleared
        n_total++; if (led_cycles !== 3 + STR - 1) $display("FAIL led_reload got=%0d exp=%0d", led_cycles, 3 + STR - 1); else n_pass++;
`else
        sweep(15, 0);
        sweep(15, 0);
        n_total++; if (led_cycles !== 0) $display("FAIL led_disabled got=%0d exp=0", led_cycles); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int col;
        bit exp_led;
        do_reset();
        col = 15;
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 499) == 0) || (m_dead && $urandom_range(0, 39) == 0);
            collision   = ($urandom_range(0, 79) == 0);
            game_active = ($urandom_range(0, 59) != 0);
            pipe_valid  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0) col = int'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) col = col;
            else if (col == 0) col = 15;
            else col = col - 1;
            pipe_col = 4'(col);
            tick();
`ifdef SCORE_LED_STRETCH_EN
            exp_led = (m_led_cnt != 0);
`else
            exp_led = 1'b0;
`endif
            n_total++; if (counter2 !== m_pulse) begin $display("FAIL rnd_counter2 cyc=%0d got=%b exp=%b", i, counter2, m_pulse); end else n_pass++;
            n_total++; if (game_over !== m_dead) begin $display("FAIL rnd_game_over cyc=%0d got=%b exp=%b", i, game_over, m_dead); end else n_pass++;
            n_total++; if (int'(pipes_passed) !== ((m_count > 255) ? 255 : m_count)) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, pipes_passed, m_count); else n_pass++;
            n_total++; if (int'(pipes_passed_s) !== ((m_count > 3) ? 3 : m_count)) $display("FAIL rnd_sat_count cyc=%0d got=%0d exp=%0d", i, pipes_passed_s, m_count); else n_pass++;
            n_total++; if (score_led !== exp_led) $display("FAIL rnd_score_led cyc=%0d got=%b exp=%b", i, score_led, exp_led); else n_pass++;
        end
        RST = 0;
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_collision_overlap();
        test_simultaneous();
        test_multi_saturate();
        test_pause_reset();
        test_score_led();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
